// File: rtl/conv_partial_sum_accumulator.sv
// Accumulates convolution partial sums across depth passes in a one-feature-map buffer;
// on the last pass it emits each finished pixel (optionally ReLU-clipped) with its address.
module conv_partial_sum_accumulator #(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 32,
    parameter int KERNAL_SIZE           = 5,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter bit RELU_ENABLE           = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             first_pass,
    input  logic                             last_pass,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             data_valid,
    output logic [DATA_WIDTH-1:0]            acc_data_out,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] acc_address_out,
    output logic                             acc_valid_out,
    output logic                             busy,
    output logic                             pass_done,
    output logic [1:0]                       dbg_state
);

    localparam int M  = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
    localparam int AW = ADDRESS_SIZE_NEXT_IFM;
    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic                  pass_done_q, pass_done_d;

    logic                  s1_valid_q;
    logic [AW-1:0]         s1_addr_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    logic                  s2_valid_q;
    logic [AW-1:0]         s2_addr_q;
    logic [DATA_WIDTH-1:0] s2_sum_q;
    logic [DATA_WIDTH-1:0] s2_sum_d;

    logic                  out_valid_q;
    logic [AW-1:0]         out_addr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;

    logic [DATA_WIDTH-1:0] buf_q [M];
    logic                  beat_accept;

    // Handshake: data_in is consumed on every rising edge where data_valid is high and
    // the state is RUN; there is no backpressure, and beats offered in IDLE or DRAIN are dropped.
    assign beat_accept = (state_q == RUN) && data_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        last_d      = last_q;
        pass_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    first_d = first_pass;
                    last_d  = last_pass;
                end
            end
            RUN: begin
                if (data_valid) begin
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d     = IDLE;
                    pass_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            last_q      <= last_d;
            pass_done_q <= pass_done_d;
        end
    end

    // Consecutive beats always hit distinct pixels, and a beat's read happens one cycle
    // after the write of the beat two ahead of it, so no forwarding path is needed.
    always_comb begin
        s2_sum_d = first_q ? s1_data_q : (buf_q[s1_addr_q] + s1_data_q);
    end

    always_comb begin
        out_data_d = s2_sum_q;
        if (RELU_ENABLE && s2_sum_q[DATA_WIDTH-1]) begin
            out_data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= '0;
            s2_sum_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= beat_accept;
            if (beat_accept) begin
                s1_addr_q <= cnt_q;
                s1_data_q <= data_in;
            end
            s2_valid_q  <= s1_valid_q;
            if (s1_valid_q) begin
                s2_addr_q <= s1_addr_q;
                s2_sum_q  <= s2_sum_d;
            end
            out_valid_q <= s2_valid_q && last_q;
            if (s2_valid_q && last_q) begin
                out_addr_q <= s2_addr_q;
                out_data_q <= out_data_d;
            end
        end
    end

    // The buffer keeps the unclipped sum; its contents are meaningless until a first pass.
    always_ff @(posedge clk) begin
        if (s2_valid_q) begin
            buf_q[s2_addr_q] <= s2_sum_q;
        end
    end

    assign acc_data_out    = out_data_q;
    assign acc_address_out = out_addr_q;
    assign acc_valid_out   = out_valid_q;
    assign busy            = (state_q != IDLE);
    assign pass_done       = pass_done_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_conv_partial_sum_accumulator.sv
// Bench for conv_partial_sum_accumulator with a 4-pixel output map, run with and
// without ReLU side by side on the same stimulus.
module tb_conv_partial_sum_accumulator;

    localparam int M = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        first_pass = 1'b0;
    logic        last_pass = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = '0;

    logic [31:0] acc_data_r, acc_data_n;
    logic [1:0]  acc_addr_r, acc_addr_n;
    logic        acc_valid_r, acc_valid_n;
    logic        busy_r, busy_n;
    logic        done_r, done_n;
    logic [1:0]  state_r, state_n;

    conv_partial_sum_accumulator #(
        .DATA_WIDTH(32), .IFM_SIZE(6), .KERNAL_SIZE(5), .RELU_ENABLE(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .first_pass(first_pass),
        .last_pass(last_pass), .data_in(data_in), .data_valid(data_valid),
        .acc_data_out(acc_data_r), .acc_address_out(acc_addr_r),
        .acc_valid_out(acc_valid_r), .busy(busy_r), .pass_done(done_r),
        .dbg_state(state_r)
    );

    conv_partial_sum_accumulator #(
        .DATA_WIDTH(32), .IFM_SIZE(6), .KERNAL_SIZE(5), .RELU_ENABLE(1'b0)
    ) dut_nr (
        .clk(clk), .reset(reset), .start(start), .first_pass(first_pass),
        .last_pass(last_pass), .data_in(data_in), .data_valid(data_valid),
        .acc_data_out(acc_data_n), .acc_address_out(acc_addr_n),
        .acc_valid_out(acc_valid_n), .busy(busy_n), .pass_done(done_n),
        .dbg_state(state_n)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] relu;
        logic [31:0] raw;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] relu;
        logic [31:0] raw;
        int          cyc;
    } cap_t;

    exp_t        exp_q[$];
    cap_t        cap_q[$];
    exp_t        e;
    logic [31:0] m_buf [M];
    logic [31:0] s;
    bit          m_active = 0;
    bit          m_first = 0;
    bit          m_last = 0;
    int          m_k = 0;
    int          m_done_due = -1;
    int          cyc = 0;
    int          last_done_cyc = -1;

    // A pass is a window of M accepted beats; each beat's result is due two edges later
    // and the pass completes three edges after its final beat.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_active   = 0;
            m_k        = 0;
            m_done_due = -1;
            exp_q.delete();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_first  = first_pass;
                m_last   = last_pass;
                m_k      = 0;
            end
        end else if (m_k < M && data_valid) begin
            s = m_first ? data_in : m_buf[m_k] + data_in;
            m_buf[m_k] = s;
            if (m_last) begin
                exp_q.push_back('{due: cyc + 2, addr: 32'(m_k),
                                  relu: (s[31] ? 32'd0 : s), raw: s});
            end
            m_k++;
            if (m_k == M) m_done_due = cyc + 3;
        end else if (m_k == M && cyc == m_done_due) begin
            m_active = 0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("valid_relu", 32'(acc_valid_r), 32'd1);
            check("valid_norelu", 32'(acc_valid_n), 32'd1);
            check("addr_relu", 32'(acc_addr_r), e.addr);
            check("addr_norelu", 32'(acc_addr_n), e.addr);
            check("data_relu", acc_data_r, e.relu);
            check("data_norelu", acc_data_n, e.raw);
        end else begin
            check("idle_valid_relu", 32'(acc_valid_r), 32'd0);
            check("idle_valid_norelu", 32'(acc_valid_n), 32'd0);
        end
        check("busy_relu", 32'(busy_r), 32'(m_active));
        check("busy_norelu", 32'(busy_n), 32'(m_active));
        check("pass_done_relu", 32'(done_r), 32'(cyc == m_done_due));
        check("pass_done_norelu", 32'(done_n), 32'(cyc == m_done_due));
        if (acc_valid_r) cap_q.push_back('{addr: 32'(acc_addr_r), relu: acc_data_r,
                                           raw: acc_data_n, cyc: cyc});
        if (done_r) last_done_cyc = cyc;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (!busy_r && !busy_n) ok = 1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_idle: busy still 1 after 40 cycles, expected 0");
        end
    endtask

    // Called at negedge+1; the start pulse is raised immediately so a pass issued right
    // after wait_idle lands in the pass_done cycle.
    task automatic run_pass(input bit f, input bit l,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input bit gap, input bit mid_start, input bit drain_junk);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        start = 1; first_pass = f; last_pass = l;
        step();
        start = 0;
        first_pass = 1'($urandom_range(0, 1));
        last_pass  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) begin
            data_valid = 1; data_in = d[i];
            start = mid_start && (i == 2);
            step();
            start = 0;
            if (gap) begin
                data_valid = 0; data_in = $urandom;
                step();
            end
        end
        data_valid = drain_junk; data_in = $urandom;
        wait_idle();
        data_valid = 0;
    endtask

    task automatic check_caps(input string tag,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3,
                              input logic [31:0] n0, input logic [31:0] n1,
                              input logic [31:0] n2, input logic [31:0] n3);
        logic [31:0] er [4];
        logic [31:0] en [4];
        er = '{r0, r1, r2, r3};
        en = '{n0, n1, n2, n3};
        check({tag, " pulse_count"}, 32'(cap_q.size()), 32'd4);
        for (int i = 0; i < cap_q.size() && i < 4; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), cap_q[i].addr, 32'(i));
            check($sformatf("%s relu[%0d]", tag, i), cap_q[i].relu, er[i]);
            check($sformatf("%s raw[%0d]", tag, i), cap_q[i].raw, en[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1;
        repeat (3) step();
        check("reset acc_data", acc_data_r, 32'd0);
        check("reset acc_addr", 32'(acc_addr_r), 32'd0);
        check("reset acc_valid", 32'(acc_valid_r), 32'd0);
        check("reset busy", 32'(busy_r), 32'd0);
        check("reset pass_done", 32'(done_r), 32'd0);
        check("reset state_relu", 32'(state_r), 32'd0);
        check("reset state_norelu", 32'(state_n), 32'd0);
        reset = 0;

        // single pass, back to back
        cap_q.delete();
        run_pass(1, 1, 32'd5, 32'hFFFF_FFFD, 32'd7, 32'd0, 0, 0, 0);
        check_caps("single", 32'd5, 32'd0, 32'd7, 32'd0,
                   32'd5, 32'hFFFF_FFFD, 32'd7, 32'd0);
        if (cap_q.size() == 4) begin
            check("single burst_span", 32'(cap_q[3].cyc - cap_q[0].cyc), 32'd3);
            check("single done_latency", 32'(last_done_cyc - cap_q[0].cyc), 32'd4);
        end

        // three passes, consecutive starts land in the pass_done cycle
        cap_q.delete();
        run_pass(1, 0, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0);
        run_pass(0, 0, 32'd10, 32'd20, 32'd30, 32'd40, 0, 0, 0);
        check("three no_output_early", 32'(cap_q.size()), 32'd0);
        run_pass(0, 1, 32'hFFFF_FFEC, 32'd0, 32'd1, 32'hFFFF_FFCE, 0, 0, 0);
        check_caps("three", 32'd0, 32'd22, 32'd34, 32'd0,
                   32'hFFFF_FFF7, 32'd22, 32'd34, 32'hFFFF_FFFA);
        check("model buf0", m_buf[0], 32'hFFFF_FFF7);
        check("model buf3", m_buf[3], 32'hFFFF_FFFA);

        // gapped data_valid
        cap_q.delete();
        run_pass(1, 1, 32'd5, 32'hFFFF_FFFD, 32'd7, 32'd0, 1, 0, 0);
        check_caps("gapped", 32'd5, 32'd0, 32'd7, 32'd0,
                   32'd5, 32'hFFFF_FFFD, 32'd7, 32'd0);

        // ignored start in RUN, ignored data_valid in IDLE and DRAIN
        run_pass(1, 0, 32'd1, 32'd1, 32'd1, 32'd1, 0, 0, 0);
        data_valid = 1; data_in = 32'd77;
        step();
        step();
        cap_q.delete();
        run_pass(0, 1, 32'd9, 32'hFFFF_FFF8, 32'd7, 32'd6, 0, 1, 1);
        check_caps("ignored", 32'd10, 32'd0, 32'd8, 32'd7,
                   32'd10, 32'hFFFF_FFF9, 32'd8, 32'd7);

        // signed overflow wraps
        run_pass(1, 0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 0, 0, 0);
        cap_q.delete();
        run_pass(0, 1, 32'd1, 32'd0, 32'd0, 32'd0, 0, 0, 0);
        check_caps("overflow", 32'd0, 32'd0, 32'd0, 32'd0,
                   32'h8000_0000, 32'd0, 32'd0, 32'd0);

        // reset mid-pass
        cap_q.delete();
        start = 1; first_pass = 1; last_pass = 1;
        step();
        start = 0; data_valid = 1; data_in = 32'd11;
        step();
        data_in = 32'd12;
        step();
        data_valid = 0;
        step();
        check("midreset pre_output_count", 32'(cap_q.size()), 32'd1);
        reset = 1;
        #1;
        check("midreset acc_valid", 32'(acc_valid_r), 32'd0);
        check("midreset acc_data", acc_data_r, 32'd0);
        check("midreset acc_addr", 32'(acc_addr_n), 32'd0);
        check("midreset busy", 32'(busy_r), 32'd0);
        check("midreset busy_norelu", 32'(busy_n), 32'd0);
        step();
        step();
        reset = 0;
        check("midreset no_more_output", 32'(cap_q.size()), 32'd1);
        cap_q.delete();
        run_pass(1, 1, 32'd3, 32'hFFFF_FFFC, 32'd5, 32'd6, 0, 0, 0);
        check_caps("after_reset", 32'd3, 32'd0, 32'd5, 32'd6,
                   32'd3, 32'hFFFF_FFFC, 32'd5, 32'd6);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
